// File: rtl/key_tone_synth_if.sv
// Key-event and tone-output bundle for key_tone_synth.
// The master drives key events and enable; the slave is the synth.
interface key_tone_synth_if;
  logic       en;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_released;
  logic       audio_out;
  logic [2:0] note_id;
  logic       note_start;
  logic [7:0] note_count;

  modport master (
    output en, key_code, key_valid, key_released,
    input  audio_out, note_id, note_start, note_count
  );

  modport slave (
    input  en, key_code, key_valid, key_released,
    output audio_out, note_id, note_start, note_count
  );
endinterface

// File: rtl/key_tone_synth.sv
// Scan-code driven square-wave tone generator (C4-B4) with hold timeout
// and a saturating count of accepted notes.
module key_tone_synth #(
  parameter bit          SIM_FAST = 1'b0,
  parameter int unsigned HOLD_MAX = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  key_tone_synth_if.slave bus
);

  localparam int unsigned SHIFT  = SIM_FAST ? 10 : 0;
  localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e              state_q, state_d;
  logic [2:0]          note_q, note_d;
  logic                audio_q, audio_d;
  logic [17:0]         phase_q, phase_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                start_q, start_d;
  logic [7:0]          count_q, count_d;

  logic [2:0]  key_note;
  logic        accept;
  logic        go_idle;
  logic [17:0] hp_last;

  function automatic logic [2:0] map_code(input logic [7:0] code);
    case (code)
      8'h1A:   return 3'd1;
      8'h22:   return 3'd2;
      8'h21:   return 3'd3;
      8'h2A:   return 3'd4;
      8'h32:   return 3'd5;
      8'h31:   return 3'd6;
      8'h3A:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [17:0] half_period(input logic [2:0] n);
    case (n)
      3'd1:    return 18'(191113 >> SHIFT);
      3'd2:    return 18'(170262 >> SHIFT);
      3'd3:    return 18'(151686 >> SHIFT);
      3'd4:    return 18'(143173 >> SHIFT);
      3'd5:    return 18'(127551 >> SHIFT);
      3'd6:    return 18'(113636 >> SHIFT);
      3'd7:    return 18'(101239 >> SHIFT);
      default: return '1;
    endcase
  endfunction

  always_comb begin
    key_note = map_code(bus.key_code);
    accept   = bus.en && bus.key_valid && (key_note != 3'd0);
    hp_last  = half_period(note_q) - 18'd1;
    go_idle  = 1'b0;

    state_d = state_q;
    note_d  = note_q;
    audio_d = audio_q;
    phase_d = phase_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    count_d = count_q;

    // Disable beats everything; a mapped press beats timeout and release.
    if (!bus.en) begin
      go_idle = 1'b1;
    end else if (accept) begin
      state_d = PLAY;
      note_d  = key_note;
      audio_d = 1'b1;
      phase_d = '0;
      hold_d  = '0;
      start_d = 1'b1;
      count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end else begin
      case (state_q)
        PLAY: begin
          if (hold_q == HOLD_LAST || bus.key_released) begin
            go_idle = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
            if (phase_q == hp_last) begin
              phase_d = '0;
              audio_d = ~audio_q;
            end else begin
              phase_d = phase_q + 18'd1;
            end
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (go_idle) begin
      state_d = IDLE;
      note_d  = '0;
      audio_d = 1'b0;
      phase_d = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      note_q  <= '0;
      audio_q <= 1'b0;
      phase_q <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      audio_q <= audio_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      count_q <= count_d;
    end
  end

  assign bus.audio_out  = audio_q;
  assign bus.note_id    = note_q;
  assign bus.note_start = start_q;
  assign bus.note_count = count_q;

endmodule

// File: doc/key_tone_synth.md
KEY_TONE_SYNTH -- requirements
Module: key_tone_synth

Interface
REQ-001 Parameter: SIM_FAST, 0, when 1 every half-period constant SHALL be right-shifted by 10 (bench acceleration).
REQ-002 Parameter: HOLD_MAX, 50_000_000, maximum cycles a note SHALL sound without a release event (0.5 s at 100 MHz).
REQ-003 Port: clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: en  input  1  synth enable; low forces silence.
REQ-006 Port: key_code  input  8  scan code from upstream key source (player or keyboard).
REQ-007 Port: key_valid  input  1  one-cycle strobe: key_code is a new press.
REQ-008 Port: key_released  input  1  one-cycle strobe: current key released.
REQ-009 Port: audio_out  output  1  square-wave tone to buzzer.
REQ-010 Port: note_id  output  3  sounding note 1-7, 0 = silent.
REQ-011 Port: note_start  output  1  one-cycle pulse when a note is accepted.
REQ-012 Port: note_count  output  8  accepted-note counter, saturating.

Function
REQ-013 Code map SHALL be 1A->1, 22->2, 21->3, 2A->4, 32->5, 31->6, 3A->7; all other codes unmapped.
REQ-014 Half-period (cycles) SHALL be: 1:191113, 2:170262, 3:151686, 4:143173, 5:127551, 6:113636, 7:101239 (C4-B4 at 100 MHz), shifted per REQ-001.
REQ-015 FSM states SHALL be IDLE and PLAY only.
REQ-016 IDLE: audio_out=0, note_id=0, phase and hold counters held at 0.
REQ-017 en=1, key_valid=1, mapped code at cycle N: at N+1 state=PLAY, note_id=mapped value, audio_out=1, phase counter=0, hold counter=0, note_start=1 for exactly that cycle.
REQ-018 key_valid with unmapped code SHALL be ignored in both states (no state, output or counter change).
REQ-019 PLAY: phase counter increments each cycle; at value half-period-1 it SHALL wrap to 0 and audio_out SHALL toggle on the same edge.
REQ-020 PLAY, mapped key_valid (same or different code): retrigger per REQ-017 (phase restarts, audio_out=1, hold counter cleared).
REQ-021 PLAY, key_released=1 and key_valid=0: next cycle IDLE, audio_out=0, note_id=0.
REQ-022 key_valid and key_released in the same cycle: key_valid SHALL take priority; release ignored.
REQ-023 key_released in IDLE SHALL be ignored.
REQ-024 PLAY, hold counter reaching HOLD_MAX-1: next cycle IDLE (auto-release), regardless of further release events.
REQ-025 en=0: next cycle IDLE; key_valid/key_released ignored while en=0; note_count holds.
REQ-026 note_count SHALL increment by 1 on every note_start and saturate at 255.
REQ-027 Counters SHALL be wide enough for the largest constant (phase 18 bits, hold 26 bits); no truncation.

Reset
REQ-028 rst=1 at any edge SHALL give next cycle: state=IDLE, audio_out=0, note_id=0, note_start=0, note_count=0, all counters 0, overriding en and strobes.
REQ-029 rst asserted mid-note SHALL silence output on the following cycle with no residual toggle.

Verification
REQ-030 SIM_FAST=1, en=1, key_code=1A, key_valid pulse -> note_start 1 cycle, note_id=1, audio_out toggles every 186 cycles.
REQ-031 Note 6 (31) playing, key_valid with 3A -> note_id=7, phase restarts, half-period 98 cycles, note_count +1.
REQ-032 key_valid(32) and key_released same cycle -> note_id=5, PLAY; next lone key_released -> IDLE, audio_out=0.
REQ-033 key_valid with code 1C -> no note_start, state and note_count unchanged; HOLD_MAX=1000 with no release -> IDLE after 1000 cycles.
REQ-034 300 accepted notes -> note_count=255; rst mid-note -> all outputs 0 next cycle; en=0 mid-note -> IDLE next cycle, strobes ignored.
